// File: rtl/i2c_reg_write_ctrl.sv
// Write-only I2C slave for the register bank: oversampled SCL/SDA, START/STOP framing,
// ACK pull-down and one-clock register write strobes with auto-incrementing pointer.
//
//   state    | meaning
//   IDLE     | bus idle or not addressed; wait for START
//   ADDR     | shifting in slave address + R/W
//   ACK_ADDR | holding address ACK until the ACK clock ends
//   REG      | shifting in register pointer
//   ACK_REG  | holding pointer ACK
//   DATA     | shifting in a data byte
//   ACK_DATA | ACK (or NACK) slot after a data byte
module i2c_reg_write_ctrl #(
    parameter logic [6:0] I2C_ADDR    = 7'h47,
    parameter int         NUM_REGS    = 11,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       addr_err
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, REG, ACK_REG, DATA, ACK_DATA
    } state_t;

    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_hist, sda_hist;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       byte_done, byte_done_nxt;
    logic [3:0] ptr, ptr_nxt;
    logic       sda_oe_nxt, wr_en_nxt, busy_nxt, addr_err_nxt;
    logic [3:0] wr_addr_nxt;
    logic [7:0] wr_data_nxt;

    // Synchronisers reset to the idle-high bus level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            byte_done <= byte_done_nxt;
            ptr       <= ptr_nxt;
            sda_oe    <= sda_oe_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            busy      <= busy_nxt;
            addr_err  <= addr_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        byte_done_nxt = byte_done;
        ptr_nxt       = ptr;
        sda_oe_nxt    = sda_oe;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        busy_nxt      = busy;
        addr_err_nxt  = addr_err;

        if (stop_det) begin
            state_nxt     = IDLE;
            bit_cnt_nxt   = '0;
            byte_done_nxt = 1'b0;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
        end else if (start_det) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = '0;
            byte_done_nxt = 1'b0;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
        end else begin
            case (state)
                ADDR, REG, DATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[6:0], sda_s};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done_nxt = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        // Byte complete: decide ACK on the falling edge that opens the 9th clock.
                        byte_done_nxt = 1'b0;
                        if (state == ADDR) begin
                            if (shreg[7:1] == I2C_ADDR && !shreg[0]) begin
                                state_nxt  = ACK_ADDR;
                                sda_oe_nxt = 1'b1;
                                busy_nxt   = 1'b1;
                            end else begin
                                state_nxt    = IDLE;
                                addr_err_nxt = 1'b1;
                            end
                        end else if (state == REG) begin
                            state_nxt  = ACK_REG;
                            ptr_nxt    = shreg[3:0];
                            sda_oe_nxt = 1'b1;
                        end else begin
                            state_nxt = ACK_DATA;
                            if ({1'b0, ptr} < NUM_REGS_W) begin
                                sda_oe_nxt  = 1'b1;
                                wr_en_nxt   = 1'b1;
                                wr_addr_nxt = ptr;
                                wr_data_nxt = shreg;
                                ptr_nxt     = ptr + 4'd1;
                            end
                        end
                    end
                end
                ACK_ADDR, ACK_REG, ACK_DATA: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = (state == ACK_ADDR) ? REG : DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
